// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES inverse-cipher round controller.
package aes_dec_pkg;

    localparam int NR_AES128   = 10;
    localparam int NR_AES192   = 12;
    localparam int NR_AES256   = 14;
    localparam int ROUND_IDX_W = 4;

    typedef logic [ROUND_IDX_W-1:0] round_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } dec_state_e;

    function automatic logic is_busy_state(input dec_state_e s);
        return (s == INIT) || (s == ROUND) || (s == FINAL);
    endfunction

endpackage

// File: rtl/aes_dec_round_cnt.sv
// Round-index down-counter: loads a start value, decrements on request and
// saturates at zero so the index can never wrap.
module aes_dec_round_cnt
    import aes_dec_pkg::*;
#(
    parameter int W = ROUND_IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the AES inverse-cipher datapath: INIT, NR-1 full rounds, FINAL.
// Optional key-valid stall is enabled with `define AES_DEC_KEY_STALL_EN.
module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          flush_i,
`ifdef AES_DEC_KEY_STALL_EN
    input  logic          key_vld_i,
`endif
    output logic          ready_o,
    output logic          busy_o,
    output logic          ld_state_o,
    output logic          state_en_o,
    output logic          inv_mix_en_o,
    output logic [RW-1:0] round_o,
    output logic          done_o
);

    localparam logic [RW-1:0] NR_LD = RW'(NR);

    dec_state_e    state_q;
    dec_state_e    state_d;
    logic          keyOk;
    logic          cntLoad;
    logic          cntDec;
    logic [RW-1:0] cnt;
    logic          cntZero;
    logic          cntOne;

`ifdef AES_DEC_KEY_STALL_EN
    assign keyOk = key_vld_i;
`else
    assign keyOk = 1'b1;
`endif

    aes_dec_round_cnt #(
        .W(RW)
    ) u_round_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cntLoad),
        .load_val_i(NR_LD),
        .dec_i     (cntDec),
        .cnt_o     (cnt),
        .zero_o    (cntZero),
        .one_o     (cntOne)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A missing key freezes both the state and the counter; flush still wins.
    always_comb begin
        state_d      = state_q;
        cntLoad      = 1'b0;
        cntDec       = 1'b0;
        ready_o      = 1'b0;
        ld_state_o   = 1'b0;
        state_en_o   = 1'b0;
        inv_mix_en_o = 1'b0;
        round_o      = '0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (!flush_i && start_i) begin
                    state_d = INIT;
                    cntLoad = 1'b1;
                end
            end
            INIT: begin
                ld_state_o = keyOk;
                round_o    = cnt;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (keyOk) begin
                    cntDec  = 1'b1;
                    state_d = cntOne ? FINAL : ROUND;
                end
            end
            ROUND: begin
                state_en_o   = keyOk;
                inv_mix_en_o = 1'b1;
                round_o      = cnt;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (keyOk) begin
                    cntDec = 1'b1;
                    if (cntOne || cntZero) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                state_en_o = keyOk;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (keyOk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
                if (!flush_i && start_i) begin
                    state_d = INIT;
                    cntLoad = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = is_busy_state(state_q);

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Scoreboard bench for aes_dec_round_ctrl with NR=10, 12 and 14 instances.
// The stall scenarios run only when AES_DEC_KEY_STALL_EN is defined.
module tb_aes_dec_round_ctrl;

    typedef struct {
        int         dut;
        int         cyc;
        logic       ready;
        logic       busy;
        logic       ld;
        logic       sten;
        logic       mix;
        logic [3:0] round;
        logic       done;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] startV;
    logic       flush;
`ifdef AES_DEC_KEY_STALL_EN
    logic [2:0] keyVld;
`endif

    logic       readyO [3];
    logic       busyO  [3];
    logic       ldO    [3];
    logic       stenO  [3];
    logic       mixO   [3];
    logic [3:0] roundO [3];
    logic       doneO  [3];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    rec_t expQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NRG = (g == 0) ? 10 : ((g == 1) ? 12 : 14);
        aes_dec_round_ctrl #(
            .NR(NRG),
            .RW(4)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_i     (startV[g]),
            .flush_i     (flush),
`ifdef AES_DEC_KEY_STALL_EN
            .key_vld_i   (keyVld[g]),
`endif
            .ready_o     (readyO[g]),
            .busy_o      (busyO[g]),
            .ld_state_o  (ldO[g]),
            .state_en_o  (stenO[g]),
            .inv_mix_en_o(mixO[g]),
            .round_o     (roundO[g]),
            .done_o      (doneO[g])
        );
    end

    function automatic void pushExp(input int d, input int c, input logic rdy, input logic bsy,
                                    input logic ld, input logic se, input logic mx,
                                    input int rnd, input logic dn);
        rec_t r;
        r.dut = d; r.cyc = c; r.ready = rdy; r.busy = bsy; r.ld = ld;
        r.sten = se; r.mix = mx; r.round = 4'(rnd); r.done = dn;
        expQ.push_back(r);
    endfunction

    function automatic void pushIdle(input int d, input int c);
        pushExp(d, c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endfunction

    // Expected per-cycle outputs of one block accepted so that INIT is in cycle a;
    // cycles at or after cut are not pushed (aborted block).
    function automatic void pushBlock(input int d, input int nr, input int a, input int stallR,
                                      input int stallN, input int cut, input bit tail);
        int c = a;
        if (c < cut) pushExp(d, c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, nr, 1'b0);
        c++;
        for (int r = nr - 1; r >= 1; r--) begin
            if (r == stallR) begin
                for (int s = 0; s < stallN; s++) begin
                    if (c < cut) pushExp(d, c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, r, 1'b0);
                    c++;
                end
            end
            if (c < cut) pushExp(d, c, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, r, 1'b0);
            c++;
        end
        if (c < cut) pushExp(d, c, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        c++;
        if (c < cut) pushExp(d, c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        c++;
        if (tail && c < cut) pushIdle(d, c);
    endfunction

    task automatic checkOutput(input rec_t e);
        int d = e.dut;
        total++;
        if (readyO[d] !== e.ready || busyO[d] !== e.busy || ldO[d] !== e.ld ||
            stenO[d] !== e.sten || mixO[d] !== e.mix || roundO[d] !== e.round ||
            doneO[d] !== e.done) begin
            bad++;
            $display("[TB] FAIL outputs dut%0d cyc%0d got rdy=%b bsy=%b ld=%b en=%b mix=%b rnd=%0d done=%b required rdy=%b bsy=%b ld=%b en=%b mix=%b rnd=%0d done=%b",
                     d, e.cyc, readyO[d], busyO[d], ldO[d], stenO[d], mixO[d], roundO[d], doneO[d],
                     e.ready, e.busy, e.ld, e.sten, e.mix, e.round, e.done);
        end
    endtask

    // Monitor: compares every expectation due this cycle and flags unexpected done pulses.
    always @(negedge clk) begin : monitor
        rec_t keep[$];
        bit   seen[3];
        keep = {};
        seen = '{default: 1'b0};
        foreach (expQ[i]) begin
            if (expQ[i].cyc == cyc) begin
                seen[expQ[i].dut] = 1'b1;
                checkOutput(expQ[i]);
            end else if (expQ[i].cyc > cyc) begin
                keep.push_back(expQ[i]);
            end else begin
                total++;
                bad++;
                $display("[TB] FAIL stale dut%0d expected cyc%0d still pending at cyc%0d", expQ[i].dut, expQ[i].cyc, cyc);
            end
        end
        expQ = keep;
        for (int d = 0; d < 3; d++) begin
            if (doneO[d] === 1'b1 && !seen[d]) begin
                total++;
                bad++;
                $display("[TB] FAIL spurious_done dut%0d cyc%0d got done=1 required done=0", d, cyc);
            end
        end
    end

    task automatic gotoCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int c, input logic [2:0] st, input logic fl);
        gotoCycle(c);
        startV = st;
        flush  = fl;
    endtask

    initial begin
        rst_n  = 1'b0;
        startV = 3'b000;
        flush  = 1'b0;
`ifdef AES_DEC_KEY_STALL_EN
        keyVld = 3'b111;
`endif
        for (int d = 0; d < 3; d++) begin
            pushIdle(d, 1);
            pushIdle(d, 2);
        end
        gotoCycle(2);
        #3 rst_n = 1'b1;

        // Single blocks on all three widths; a start while busy must be ignored.
        pushBlock(0, 10, 4, 0, 0, 1000, 1'b1);
        pushBlock(1, 12, 4, 0, 0, 1000, 1'b1);
        pushBlock(2, 14, 4, 0, 0, 1000, 1'b1);
        applyStimulus(3, 3'b111, 1'b0);
        applyStimulus(4, 3'b000, 1'b0);
        applyStimulus(7, 3'b001, 1'b0);
        applyStimulus(8, 3'b000, 1'b0);

        // Back-to-back blocks with start held high.
        pushBlock(0, 10, 23, 0, 0, 1000, 1'b0);
        pushBlock(0, 10, 35, 0, 0, 1000, 1'b1);
        applyStimulus(22, 3'b001, 1'b0);
        applyStimulus(35, 3'b000, 1'b0);

        // Flush while round_o is 6, then a clean block.
        pushBlock(0, 10, 50, 0, 0, 55, 1'b0);
        pushIdle(0, 55);
        pushIdle(0, 56);
        pushBlock(0, 10, 57, 0, 0, 1000, 1'b1);
        applyStimulus(49, 3'b001, 1'b0);
        applyStimulus(50, 3'b000, 1'b0);
        applyStimulus(54, 3'b000, 1'b1);
        applyStimulus(55, 3'b000, 1'b0);
        applyStimulus(56, 3'b001, 1'b0);
        applyStimulus(57, 3'b000, 1'b0);

        // Flush and start together in IDLE: start is dropped.
        pushIdle(0, 70);
        pushIdle(0, 71);
        pushIdle(0, 72);
        applyStimulus(70, 3'b001, 1'b1);
        applyStimulus(71, 3'b000, 1'b0);

        // Flush and start together in DONE: back to IDLE, not INIT.
        pushBlock(0, 10, 73, 0, 0, 1000, 1'b0);
        pushIdle(0, 85);
        pushIdle(0, 86);
        applyStimulus(72, 3'b001, 1'b0);
        applyStimulus(73, 3'b000, 1'b0);
        applyStimulus(84, 3'b001, 1'b1);
        applyStimulus(85, 3'b000, 1'b0);

        // Asynchronous reset two cycles into a block.
        pushBlock(0, 10, 89, 0, 0, 91, 1'b0);
        for (int d = 0; d < 3; d++) pushIdle(d, 91);
        pushIdle(0, 92);
        pushIdle(0, 93);
        applyStimulus(88, 3'b001, 1'b0);
        applyStimulus(89, 3'b000, 1'b0);
        gotoCycle(91);
        #1 rst_n = 1'b0;
        gotoCycle(92);
        #3 rst_n = 1'b1;

`ifdef AES_DEC_KEY_STALL_EN
        // Key stall of three cycles on round 7.
        pushBlock(0, 10, 96, 7, 3, 1000, 1'b1);
        applyStimulus(95, 3'b001, 1'b0);
        applyStimulus(96, 3'b000, 1'b0);
        gotoCycle(99);
        keyVld = 3'b110;
        gotoCycle(102);
        keyVld = 3'b111;

        // Flush during a key stall.
        pushBlock(0, 10, 113, 7, 3, 117, 1'b0);
        pushIdle(0, 117);
        pushIdle(0, 118);
        applyStimulus(112, 3'b001, 1'b0);
        applyStimulus(113, 3'b000, 1'b0);
        gotoCycle(116);
        keyVld = 3'b110;
        flush  = 1'b1;
        gotoCycle(117);
        keyVld = 3'b111;
        flush  = 1'b0;
`endif

        gotoCycle(125);
        @(negedge clk);
        #1;
        foreach (expQ[i]) begin
            total++;
            bad++;
            $display("[TB] FAIL unchecked dut%0d expected cyc%0d never compared", expQ[i].dut, expQ[i].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
